// File: rtl/ppt_reg_arbiter_pkg.sv
// ppt_reg_arbiter_pkg: shared FSM encoding, STATUS bit indices and default RO mask
package ppt_reg_arbiter_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_I2C = 2'd1;
  localparam logic [1:0] ARB_CORE = 2'd2;
  localparam int OVR = 0;
  localparam int ROV = 1;
  localparam logic [7:0] DEF_RO_MASK = 8'hC0;
endpackage

// File: rtl/ppt_sync_pulse.sv
// ppt_sync_pulse: two-flop synchroniser plus edge flop giving a one-cycle rising-edge pulse
module ppt_sync_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);
  logic [2:0] sync_q;
  // shift the asynchronous input through the synchroniser and edge flop
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[1:0], d_i};
  assign pulse_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/ppt_reg_arbiter.sv
// ppt_reg_arbiter: config register bank with alternating-priority I2C/core write arbitration
module ppt_reg_arbiter
  import ppt_reg_arbiter_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = 3,
  parameter logic [NUM_REGS-1:0] RO_MASK = DEF_RO_MASK,
  parameter logic [NUM_REGS*8-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_write,
  input  logic [7:0]            i2c_addr,
  input  logic [7:0]            i2c_wdata,
  output logic [7:0]            i2c_rdata,
  input  logic                  core_req,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [7:0]            core_wdata,
  output logic                  core_gnt,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic [NUM_REGS-1:0]   upd_strobe,
  output logic                  err_flag
);
  localparam int ST = NUM_REGS - 1;
  logic i2c_pulse, i2c_req, i2c_st, i2c_ok, core_ok;
  logic [1:0] state_q, state_d, st_set, st_clr;
  logic pend_q, pend_d, last_core_q, last_core_d;
  logic [7:0] h_addr_q, h_data_q, c_data_q, rdata_q;
  logic [ADDR_W-1:0] c_addr_q;
  logic [7:0] bank_q [NUM_REGS];
  logic [7:0] bank_d [NUM_REGS];
  logic [NUM_REGS-1:0] strobe;

  ppt_sync_pulse u_sync (.clk(clk), .rst(rst), .d_i(i2c_write), .pulse_o(i2c_pulse));

  assign i2c_st = int'(h_addr_q) == ST;
  assign i2c_ok = int'(h_addr_q) < ST && !RO_MASK[h_addr_q[ADDR_W-1:0]];
  assign core_ok = int'(c_addr_q) < ST;

  // arbitration: a held or just-detected I2C write races core_req; ties alternate
  always_comb begin
    i2c_req = pend_q | i2c_pulse;
    state_d = state_q != ARB_IDLE ? ARB_IDLE :
              (i2c_req && (!core_req || last_core_q)) ? ARB_I2C :
              core_req ? ARB_CORE : ARB_IDLE;
    last_core_d = (state_q == ARB_IDLE && i2c_req && core_req) ? !last_core_q : last_core_q;
    pend_d = (i2c_pulse && !pend_q) ? 1'b1 : state_q == ARB_I2C ? 1'b0 : pend_q;
  end

  // commit decode: strobe the written register and update STATUS with set over clear
  always_comb begin
    strobe = '0;
    if (state_q == ARB_I2C && (i2c_ok || i2c_st)) strobe[h_addr_q[ADDR_W-1:0]] = 1'b1;
    if (state_q == ARB_CORE && core_ok) strobe[c_addr_q] = 1'b1;
    st_set = '0;
    st_set[OVR] = i2c_pulse & pend_q;
    st_set[ROV] = state_q == ARB_I2C && !i2c_ok && !i2c_st;
    st_clr = (state_q == ARB_I2C && i2c_st) ? h_data_q[1:0] : 2'b00;
    for (int i = 0; i < ST; i++)
      bank_d[i] = strobe[i] ? (state_q == ARB_CORE ? c_data_q : h_data_q) : bank_q[i];
    bank_d[ST] = {6'b0, st_set | (bank_q[ST][1:0] & ~st_clr)};
  end

  // state, holding registers, bank and registered read-back
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ARB_IDLE;
      pend_q <= 1'b0;
      last_core_q <= 1'b1;
      h_addr_q <= '0;
      h_data_q <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= i == ST ? 8'h00 : RESET_VAL[8*i +: 8];
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      last_core_q <= last_core_d;
      if (i2c_pulse && !pend_q) begin
        h_addr_q <= i2c_addr;
        h_data_q <= i2c_wdata;
      end
      if (state_d == ARB_CORE) begin
        c_addr_q <= core_addr;
        c_data_q <= core_wdata;
      end
      rdata_q <= int'(i2c_addr) < NUM_REGS ? bank_q[i2c_addr[ADDR_W-1:0]] : 8'h00;
      bank_q <= bank_d;
    end

  for (genvar g = 0; g < NUM_REGS; g++) assign regs_flat[8*g +: 8] = bank_q[g];
  assign i2c_rdata = rdata_q;
  assign core_gnt = state_q == ARB_CORE;
  assign upd_strobe = strobe;
  assign err_flag = |bank_q[ST][1:0];
endmodule

// File: tb/tb_ppt_reg_arbiter.sv
// tb_ppt_reg_arbiter: directed vector table plus hand sequences for ties, overrun and reset
module tb_ppt_reg_arbiter;
  localparam logic [63:0] RV = 64'h17161514_13121110;
  localparam logic [63:0] RV_OUT = 64'h00161514_13121110;
  logic clk = 1'b0, rst = 1'b0, i2c_write = 1'b0, core_req = 1'b0;
  logic [7:0] i2c_addr = '0, i2c_wdata = '0, core_wdata = '0;
  logic [2:0] core_addr = '0;
  logic [7:0] i2c_rdata, upd_strobe;
  logic core_gnt, err_flag;
  logic [63:0] regs_flat;
  int checks = 0, failures = 0;

  typedef struct {
    logic core;
    logic [7:0] addr, data, strobe;
    int idx;
    logic [7:0] pre, post, st;
  } vec_t;
  vec_t tbl [12];
  vec_t v;

  always #5 clk = ~clk;

  ppt_reg_arbiter #(.RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .i2c_write(i2c_write), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_rdata(i2c_rdata), .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .regs_flat(regs_flat), .upd_strobe(upd_strobe), .err_flag(err_flag)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%016h expected=%016h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'h07, 8'h01, 8'h80, 7, 8'h01, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 8'h02, 8'hA5, 8'h04, 2, 8'h12, 8'hA5, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 8'h01, 8'h01, 0, 8'h10, 8'h01, 8'h00};
    tbl[3]  = '{1'b1, 8'h03, 8'hC3, 8'h08, 3, 8'h3C, 8'hC3, 8'h00};
    tbl[4]  = '{1'b1, 8'h06, 8'h5A, 8'h40, 6, 8'h16, 8'h5A, 8'h00};
    tbl[5]  = '{1'b0, 8'h06, 8'hFF, 8'h00, 6, 8'h5A, 8'h5A, 8'h02};
    tbl[6]  = '{1'b0, 8'h07, 8'h02, 8'h80, 7, 8'h02, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 8'h09, 8'h33, 8'h00, 5, 8'h55, 8'h55, 8'h02};
    tbl[8]  = '{1'b0, 8'h07, 8'h03, 8'h80, 7, 8'h02, 8'h00, 8'h00};
    tbl[9]  = '{1'b1, 8'h07, 8'h99, 8'h00, 7, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{1'b0, 8'h01, 8'h88, 8'h02, 1, 8'h77, 8'h88, 8'h00};
    tbl[11] = '{1'b1, 8'h00, 8'hC3, 8'h01, 0, 8'h01, 8'hC3, 8'h00};

    rst = 1'b1;
    tick(2);
    chk64("reset_regs", regs_flat, RV_OUT);
    chk8("reset_rdata", i2c_rdata, 8'h00);
    chk8("reset_err", 8'(err_flag), 8'h00);
    chk8("reset_gnt", 8'(core_gnt), 8'h00);
    chk8("reset_strobe", upd_strobe, 8'h00);
    rst = 1'b0;
    tick(2);
    chk64("idle_regs", regs_flat, RV_OUT);

    // first tie: I2C wins, core follows two cycles later
    i2c_addr = 8'h01; i2c_wdata = 8'h77; i2c_write = 1'b1;
    tick(2);
    core_addr = 3'd3; core_wdata = 8'h3C; core_req = 1'b1;
    tick();
    chk8("tie1_i2c_strobe", upd_strobe, 8'h02);
    chk8("tie1_no_gnt", 8'(core_gnt), 8'h00);
    tick();
    chk8("tie1_reg1", regs_flat[15:8], 8'h77);
    chk8("tie1_gap_gnt", 8'(core_gnt), 8'h00);
    tick();
    chk8("tie1_gnt", 8'(core_gnt), 8'h01);
    chk8("tie1_core_strobe", upd_strobe, 8'h08);
    core_req = 1'b0; i2c_write = 1'b0;
    tick();
    chk8("tie1_reg3", regs_flat[31:24], 8'h3C);
    tick(3);

    // second tie: core wins; a second I2C edge during the wait overruns
    i2c_addr = 8'h04; i2c_wdata = 8'h44; i2c_write = 1'b1;
    tick(2);
    core_addr = 3'd5; core_wdata = 8'h55; core_req = 1'b1; i2c_write = 1'b0;
    tick();
    chk8("tie2_gnt_first", 8'(core_gnt), 8'h01);
    chk8("tie2_core_strobe", upd_strobe, 8'h20);
    core_req = 1'b0; i2c_write = 1'b1; i2c_addr = 8'h00; i2c_wdata = 8'hEE;
    tick();
    chk8("tie2_reg5", regs_flat[47:40], 8'h55);
    chk8("tie2_gnt_off", 8'(core_gnt), 8'h00);
    tick();
    chk8("tie2_i2c_strobe", upd_strobe, 8'h10);
    tick();
    chk8("ovr_reg4_kept", regs_flat[39:32], 8'h44);
    chk8("ovr_reg0_dropped", regs_flat[7:0], 8'h10);
    chk8("ovr_status", regs_flat[63:56], 8'h01);
    chk8("ovr_err", 8'(err_flag), 8'h01);
    i2c_write = 1'b0;
    tick(4);

    for (int k = 0; k < 12; k++) begin
      v = tbl[k];
      if (v.core) begin
        core_addr = v.addr[2:0]; core_wdata = v.data; core_req = 1'b1;
        tick();
        chk8($sformatf("v%0d_gnt", k), 8'(core_gnt), 8'h01);
        chk8($sformatf("v%0d_strobe", k), upd_strobe, v.strobe);
        chk8($sformatf("v%0d_pre", k), regs_flat[8*v.idx +: 8], v.pre);
        core_req = 1'b0;
        tick();
        chk8($sformatf("v%0d_gnt_off", k), 8'(core_gnt), 8'h00);
      end else begin
        i2c_addr = v.addr; i2c_wdata = v.data; i2c_write = 1'b1;
        tick(3);
        chk8($sformatf("v%0d_strobe", k), upd_strobe, v.strobe);
        chk8($sformatf("v%0d_pre", k), regs_flat[8*v.idx +: 8], v.pre);
        tick();
        i2c_write = 1'b0;
        tick(3);
      end
      chk8($sformatf("v%0d_post", k), regs_flat[8*v.idx +: 8], v.post);
      chk8($sformatf("v%0d_status", k), regs_flat[63:56], v.st);
      chk8($sformatf("v%0d_err", k), 8'(err_flag), 8'(|v.st));
      i2c_addr = 8'(v.idx);
      tick();
      chk8($sformatf("v%0d_rdata", k), i2c_rdata, v.post);
    end

    // reset between edge detect and commit discards the write
    i2c_addr = 8'h02; i2c_wdata = 8'h99; i2c_write = 1'b1;
    tick(3);
    chk8("rstmid_strobe", upd_strobe, 8'h04);
    rst = 1'b1; i2c_write = 1'b0;
    #2;
    chk64("rstmid_regs", regs_flat, RV_OUT);
    chk8("rstmid_strobe_off", upd_strobe, 8'h00);
    chk8("rstmid_gnt", 8'(core_gnt), 8'h00);
    chk8("rstmid_err", 8'(err_flag), 8'h00);
    chk8("rstmid_rdata", i2c_rdata, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk64("rstmid_after", regs_flat, RV_OUT);
    i2c_addr = 8'h09;
    tick();
    chk8("read_addr9", i2c_rdata, 8'h00);
    i2c_addr = 8'h03;
    tick();
    chk8("read_addr3", i2c_rdata, 8'h13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ppt_reg_arbiter.md
Name: ppt_reg_arbiter

Overview:
- Owns the controller's configuration register bank and shares write access between two requesters: the I2C slave register port and the internal core logic.
- The I2C side arrives from the SCL-clocked slave, so this block synchronises it into the system clock domain.
- Arbitrates I2C and core writes with alternating priority under contention.
- Returns read data to the slave's reg_data_in and exposes all registers plus per-register update strobes to the core.

Parameters:
- NUM_REGS, 8, number of 8-bit registers; address NUM_REGS-1 is STATUS.
- ADDR_W, 3, core address width, clog2(NUM_REGS).
- RO_MASK, 8'hC0, bit i=1 marks register i as core-owned; I2C writes to it are dropped.
- RESET_VAL, {NUM_REGS{8'h00}}, flattened reset contents, register 0 in LSBs.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i2c_write  in  1  reg_write from the slave; asynchronous to clk, high for at least one SCL period.
- i2c_addr  in  8  reg_data_addr from the slave; stable from before i2c_write rises until the next ACK.
- i2c_wdata  in  8  reg_data_out from the slave; same stability as i2c_addr.
- i2c_rdata  out  8  to the slave's reg_data_in; registered.
- core_req  in  1  core write request; held until core_gnt.
- core_addr  in  ADDR_W  core write address.
- core_wdata  in  8  core write data.
- core_gnt  out  1  one-cycle pulse in the cycle the core write commits.
- regs_flat  out  NUM_REGS*8  current bank contents.
- upd_strobe  out  NUM_REGS  one-hot pulse for the register written this cycle.
- err_flag  out  1  OR of the STATUS error bits.

Behaviour:
- Reset (asynchronous, rst=1):
  - bank=RESET_VAL, STATUS=0.
  - i2c_rdata=0, core_gnt=0, upd_strobe=0, err_flag=0.
  - Synchroniser, pending flag and FSM cleared; FSM=ARB_IDLE.
  - Reset mid-write discards the write with no partial update.
- I2C sync path:
  - i2c_write passes through 2 flops, then a third flop for rising-edge detect.
  - The detected edge sets i2c_pend and captures i2c_addr/i2c_wdata into holding registers in the same edge (edge 3 after the rise).
  - An edge arriving while i2c_pend=1 sets STATUS[0] (overrun); the new write is dropped and the held one kept.
- Core path: core_addr/core_wdata are sampled when the FSM selects the core. If core_req drops before selection, no write occurs.
- FSM, states ARB_IDLE, ARB_I2C, ARB_CORE:
  - ARB_IDLE, only i2c_pend: go to ARB_I2C.
  - ARB_IDLE, only core_req: go to ARB_CORE.
  - ARB_IDLE, both pending: the requester that did not win last goes first (last_winner flop, reset value = core, so I2C wins the first tie).
  - ARB_I2C: commit the write, clear i2c_pend, return to ARB_IDLE.
  - ARB_CORE: commit the write, pulse core_gnt, return to ARB_IDLE.
  - Throughput is one write per 2 cycles.
- Latency: uncontended I2C write is visible in regs_flat at clk edge 4 after i2c_write rises. Uncontended core write commits at edge 2 after core_req is seen in ARB_IDLE.
- I2C write rules:
  - Address >= NUM_REGS-1, or RO_MASK bit set: bank unchanged, STATUS[1] (ro_violation) set.
  - Exception: address == NUM_REGS-1 is STATUS, write-1-to-clear of bits [1:0]. No violation is flagged, and upd_strobe pulses for STATUS.
- Core write rules:
  - Any register except STATUS is writable.
  - A core write to STATUS or to an address >= NUM_REGS is ignored, but core_gnt still pulses.
- upd_strobe: bit i pulses exactly in the commit cycle of a write that changes register i's write path, even if the value is unchanged.
- i2c_rdata, registered every clk from i2c_addr:
  - bank[i2c_addr] when i2c_addr < NUM_REGS-1.
  - STATUS when i2c_addr == NUM_REGS-1.
  - 8'h00 otherwise.
- STATUS: bits [7:2] read 0. Set has priority over a same-cycle clear.

Decomposition:
- Shared package holds:
  - FSM state encoding: ARB_IDLE=2'd0, ARB_I2C=2'd1, ARB_CORE=2'd2.
  - STATUS bit indices: OVR=0, ROV=1.
  - Default RO_MASK.
- Natural sub-module: ppt_sync_pulse, a 3-flop synchroniser with rising-edge detect. Reused later for other SCL-domain strobes.

Test Plan:
- Reset with RESET_VAL byte i = 8'h10+i, then release -> regs_flat matches, i2c_rdata=0, err_flag=0, FSM idle.
- I2C write addr 2, data 8'hA5 -> reg2=8'hA5 at edge 4, upd_strobe=8'b0000_0100 for one cycle, STATUS=0.
- core_req (addr 3, 8'h3C) asserted in the same cycle i2c_pend sets (addr 1, 8'h77) -> I2C commits first (first tie), core_gnt follows 2 cycles later. A second simultaneous pair -> core commits first.
- I2C write to addr 6 (RO_MASK) -> reg6 unchanged, STATUS=8'h02, err_flag=1. Then I2C write 8'h02 to addr 7 -> STATUS=0, err_flag=0.
- Second i2c_write edge while the first is still pending (core_req hogging via forced contention) -> STATUS[0]=1, first write committed, second dropped.
- Assert rst between edge detect and commit -> no write, all outputs at reset values. Read addr 9 -> i2c_rdata=8'h00.
